// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the 2x2 output-stationary systolic array controller.
//   ctrl_state_t : controller FSM states
//   FEED_CYCLES  : number of skewed feed cycles for a 2x2 product
//   IDX_rc       : element index of (row r, col c) inside a packed 2x2 matrix;
//                  element idx occupies bits [idx*W +: W]
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    localparam int FEED_CYCLES = 3;
    localparam int CNT_W       = 4;

    localparam int IDX_00 = 0;
    localparam int IDX_01 = 1;
    localparam int IDX_10 = 2;
    localparam int IDX_11 = 3;

endpackage

// File: rtl/systolic_skew_feed.sv
// -----------------------------------------------------------------------------
// systolic_skew_feed
// Produces the diagonally skewed row/column operands for the 2x2 array.
// The operands are registered: the inputs describe the controller's *next*
// cycle (feed_en = next state is FEED, t = next feed count), so the flops hold
// the operand for feed step t exactly during the cycle the controller is in
// FEED with cnt == t. Outside FEED every operand is forced to 0.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   a_mat, b_mat  : latched operand matrices {m11,m10,m01,m00}
//   feed_en       : next cycle is a feed cycle
//   t             : feed step for the next cycle (0..2)
//   a0, a1        : row operands (row 1 lags row 0 by one cycle)
//   b0, b1        : column operands (col 1 lags col 0 by one cycle)
// -----------------------------------------------------------------------------
module systolic_skew_feed
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] a_mat,
    input  logic [4*WIDTH-1:0] b_mat,
    input  logic               feed_en,
    input  logic [1:0]         t,
    output logic [WIDTH-1:0]   a0,
    output logic [WIDTH-1:0]   a1,
    output logic [WIDTH-1:0]   b0,
    output logic [WIDTH-1:0]   b1
);

    logic [WIDTH-1:0] a0_q, a1_q, b0_q, b1_q;
    logic [WIDTH-1:0] a0_d, a1_d, b0_d, b1_d;

    function automatic logic [WIDTH-1:0] elem(input logic [4*WIDTH-1:0] m,
                                              input int idx);
        return m[idx*WIDTH +: WIDTH];
    endfunction

    // a0 = A[0][t], a1 = A[1][t-1], b0 = B[t][0], b1 = B[t-1][1];
    // indices outside 0..1 leave the default 0 in place.
    always_comb begin
        a0_d = '0;
        a1_d = '0;
        b0_d = '0;
        b1_d = '0;
        if (feed_en) begin
            case (t)
                2'd0: begin
                    a0_d = elem(a_mat, IDX_00);
                    b0_d = elem(b_mat, IDX_00);
                end
                2'd1: begin
                    a0_d = elem(a_mat, IDX_01);
                    a1_d = elem(a_mat, IDX_10);
                    b0_d = elem(b_mat, IDX_10);
                    b1_d = elem(b_mat, IDX_01);
                end
                2'd2: begin
                    a1_d = elem(a_mat, IDX_11);
                    b1_d = elem(b_mat, IDX_11);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0_q <= '0;
            a1_q <= '0;
            b0_q <= '0;
            b1_q <= '0;
        end else begin
            a0_q <= a0_d;
            a1_q <= a1_d;
            b0_q <= b0_d;
            b1_q <= b1_d;
        end
    end

    assign a0 = a0_q;
    assign a1 = a1_q;
    assign b0 = b0_q;
    assign b1 = b1_q;

endmodule

// File: rtl/systolic_ctrl_2x2.sv
// -----------------------------------------------------------------------------
// systolic_ctrl_2x2
// Sequencing controller for a 2x2 output-stationary systolic array.
// Accepts one operand pair, clears the array, feeds skewed operands for three
// cycles, waits DRAIN cycles for the array pipeline to settle, captures the
// four accumulators and offers them as one result.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The source holds valid and data stable until that edge;
// the controller never drops res_valid or changes res before res_ready.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a_mat, b_mat        : {m11,m10,m01,m00}, m00 in the LSBs
//   res_valid/res_ready : result handshake (valid only in DONE)
//   res                 : {c11,c10,c01,c00}, each 2*WIDTH bits
//   busy                : any state other than IDLE
//   arr_rst             : array reset (global reset or CLEAR)
//   arr_a0/a1, arr_b0/b1: registered skewed operands to the array
//   arr_c00..arr_c11    : array accumulators
// DRAIN must be within 2..15: the last product reaches c11 one cycle after the
// final feed cycle, and the drain counter is 4 bits wide.
// -----------------------------------------------------------------------------
module systolic_ctrl_2x2
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DRAIN = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*WIDTH-1:0] a_mat,
    input  logic [4*WIDTH-1:0] b_mat,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [8*WIDTH-1:0] res,
    output logic               busy,
    output logic               arr_rst,
    output logic [WIDTH-1:0]   arr_a0,
    output logic [WIDTH-1:0]   arr_a1,
    output logic [WIDTH-1:0]   arr_b0,
    output logic [WIDTH-1:0]   arr_b1,
    input  logic [2*WIDTH-1:0] arr_c00,
    input  logic [2*WIDTH-1:0] arr_c01,
    input  logic [2*WIDTH-1:0] arr_c10,
    input  logic [2*WIDTH-1:0] arr_c11
);

    ctrl_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4*WIDTH-1:0] a_q, a_d;
    logic [4*WIDTH-1:0] b_q, b_d;
    logic [8*WIDTH-1:0] res_q, res_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (cnt_q == CNT_W'(FEED_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN - 1)) begin
                    res_d   = {arr_c11, arr_c10, arr_c01, arr_c00};
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // The feeder registers its outputs, so it is steered by next-state/count.
    systolic_skew_feed #(
        .WIDTH (WIDTH)
    ) u_skew_feed (
        .clk     (clk),
        .rst     (rst),
        .a_mat   (a_q),
        .b_mat   (b_q),
        .feed_en (state_d == ST_FEED),
        .t       (cnt_d[1:0]),
        .a0      (arr_a0),
        .a1      (arr_a1),
        .b0      (arr_b0),
        .b1      (arr_b1)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res       = res_q;
    // Global reset also clears the array.
    assign arr_rst   = rst | (state_q == ST_CLEAR);

endmodule

// File: doc/systolic_ctrl_2x2.md
# systolic_ctrl_2x2

Sequencing controller for the 2x2 output-stationary systolic array. It accepts one pair of 2x2 operand matrices per transaction over a valid/ready handshake and clears the array accumulators. It then feeds row/column operands with the diagonal skew the array needs, waits for the pipeline to drain, and returns the four 2·WIDTH-bit results over a second valid/ready handshake. It sits between the host/load path and the array instance. The array's ports connect directly to this block's `arr_*` ports.

## Interface
- `WIDTH`, 8: operand width; array results are 2·WIDTH.
- `DRAIN`, 3: idle cycles after the last feed cycle before the results are captured; legal range 2..15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  controller can accept an operand pair.
- `a_mat`  in  4·WIDTH  {a11,a10,a01,a00}; a00 in bits [WIDTH-1:0].
- `b_mat`  in  4·WIDTH  {b11,b10,b01,b00}, same packing as `a_mat`.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer takes result.
- `res`  out  8·WIDTH  {c11,c10,c01,c00}, each 2·WIDTH wide; c00 in the LSBs.
- `busy`  out  1  high in every state except IDLE.
- `arr_rst`  out  1  drives the array reset.
- `arr_a0`, `arr_a1`  out  WIDTH  row operands to the array.
- `arr_b0`, `arr_b1`  out  WIDTH  column operands to the array.
- `arr_c00`, `arr_c01`, `arr_c10`, `arr_c11`  in  2·WIDTH  array accumulator outputs.

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `a_mat` and `b_mat` into operand registers and go to CLEAR.
- **CLEAR**
  - Lasts 1 cycle with `arr_rst`=1 and all `arr_*` operands at 0.
  - Then go to FEED with cnt=0.
- **FEED**
  - Lasts 3 cycles, t = cnt = 0,1,2. Out-of-range operand indices drive 0.
  - `arr_a0` = A[0][t]; `arr_a1` = A[1][t-1].
  - `arr_b0` = B[t][0]; `arr_b1` = B[t-1][1].
  - Resulting sequences:
    - t0: (a00, 0, b00, 0)
    - t1: (a01, a10, b10, b01)
    - t2: (0, a11, 0, b11)
- **DRAIN**
  - Lasts DRAIN cycles with all operands 0.
  - On the last drain cycle, capture `arr_c*` into the result register and go to DONE.
- **DONE**
  - `res_valid`=1; `res` is stable.
  - On `res_ready`: go to IDLE.
- `in_ready` is 0 outside IDLE. `in_valid` in any other state is ignored, and no operand is lost because the source holds it.
- `arr_rst` = `rst` OR (state==CLEAR). The array is therefore cleared during global reset as well.
- Arithmetic is performed by the array only. Results wrap modulo 2^(2·WIDTH); the controller adds no saturation.

## Timing
- Reset values:
  - state = IDLE; `in_ready`=1; `res_valid`=0; `res`=0; `busy`=0.
  - all `arr_a*`/`arr_b*` = 0; `arr_rst`=1 while `rst` is high.
- Input accepted at edge k (IDLE, `in_valid`=1):
  - CLEAR in cycle k+1.
  - FEED in cycles k+2..k+4.
  - DRAIN in cycles k+5..k+4+DRAIN.
  - `res_valid` rises at cycle k+5+DRAIN, which is 8 cycles with default DRAIN.
- Output handshake:
  - `res_valid` is held with `res` stable until the edge where `res_ready`=1.
  - `res_ready` already high on entry completes DONE in 1 cycle.
  - `in_ready` returns on the next cycle, so back-to-back throughput is one transaction per 4+DRAIN+2 cycles.
- `rst` asserted mid-transaction: immediate return to reset values, latched operands are discarded, and no `res_valid` pulse occurs.
- All `arr_*` operand outputs are registered (no comb path from `a_mat` or `b_mat`).

## Structure
- Shared package `systolic_pkg`:
  - `ctrl_state_t` enum {IDLE, CLEAR, FEED, DRAIN, DONE}.
  - `FEED_CYCLES`=3.
  - Matrix packing index constants.
- Sub-module `systolic_skew_feed`:
  - Takes the latched matrices and feed cnt.
  - Produces the four registered skewed operands, forcing 0 outside FEED.
- The FSM, counter and result register stay in the top module.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]] → `res` c00=19, c01=22, c10=43, c11=50; `res_valid` rises 8 cycles after acceptance.
- A=B=[[255,255],[255,255]] with WIDTH=8 → every c = 130050 mod 65536 = 64514.
- Hold `res_ready`=0 for 10 cycles after `res_valid` → `res` stable; `in_ready`=0; a new `in_valid` is ignored. Then `res_ready`=1 → IDLE next cycle.
- Two back-to-back transactions (identity×B, then A×0) → second result equals B, then all zeros. Proves CLEAR wipes prior accumulation.
- Assert `rst` during FEED cycle t1 → `arr_rst`=1 immediately and all outputs at reset values. A subsequent fresh transaction returns the correct product.
- Monitor the `arr_*` operand sequence for A=[[1,2],[3,4]], B=[[5,6],[7,8]] → exact triples (1,0,5,0), (2,3,7,6), (0,4,0,8) on t0..t2, with zeros in CLEAR and DRAIN.
